// File: rtl/fp16_pkg.sv
// Shared FP16 field widths, exponent limit and result-class encoding
// for the FP16 datapath blocks.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int DATA_W = 1 + EXP_W + MAN_W;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_SUB  = 3'd1;
    localparam logic [2:0] CLS_NORM = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_NAN  = 3'd4;

    typedef struct packed {
        logic [2:0]        cls;
        logic [DATA_W-1:0] data;
    } fp16_entry_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational FP16 classifier: splits a half-precision word into its
// class (ZERO/SUB/NORM/INF/NAN) and sign.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [2:0]        o_class,
    output logic              o_sign
);

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;
    logic             w_man_zero;

    assign w_exp      = i_data[MAN_W +: EXP_W];
    assign w_man      = i_data[MAN_W-1:0];
    assign w_man_zero = (w_man == '0);
    assign o_sign     = i_data[DATA_W-1];

    always_comb begin
        // NOTE: default first so every path assigns o_class and no latch is inferred.
        o_class = CLS_NORM;
        if (w_exp == '0) begin
            o_class = w_man_zero ? CLS_ZERO : CLS_SUB;
        end else if (w_exp == EXP_MAX) begin
            o_class = w_man_zero ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp16_mac_result_sink.sv
// Collects MAC results a fixed latency after issue, classifies them and
// queues {class, data} in a first-word fall-through FIFO with sticky flags.
module fp16_mac_result_sink
    import fp16_pkg::*;
#(
    parameter int MAC_LATENCY = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          issue_valid,
    input  logic [15:0]                   data_out,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [15:0]                   rd_data,
    output logic [2:0]                    rd_class,
    output logic                          rd_sign,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          nan_seen
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [MAC_LATENCY-1:0] r_issue_sr;
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;
    logic                   r_nan_seen;
    fp16_entry_t            r_mem [FIFO_DEPTH];

    logic                   w_capture;
    logic [2:0]             w_cap_class;
    logic                   w_cap_sign;
    fp16_entry_t            w_cap_entry;
    fp16_entry_t            w_head;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_write;
    logic                   w_drop;

    // Issue tracker: the last stage marks the cycle data_out is valid.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_issue_sr <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's pre-edge value.
            r_issue_sr[0] <= issue_valid;
            for (int i = 1; i < MAC_LATENCY; i++) begin
                r_issue_sr[i] <= r_issue_sr[i-1];
            end
        end
    end

    assign w_capture = r_issue_sr[MAC_LATENCY-1];

    fp16_classify u_classify (
        .i_data  (data_out),
        .o_class (w_cap_class),
        .o_sign  (w_cap_sign)
    );

    assign w_cap_entry = '{cls: w_cap_class, data: {w_cap_sign, data_out[DATA_W-2:0]}};

    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = rd_valid && rd_ready;
    assign w_write = w_capture && (!w_full || w_pop);
    assign w_drop  = w_capture && w_full && !w_pop;

    // NOTE: storage is not reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (w_write) begin
            r_mem[r_wptr] <= w_cap_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_nan_seen <= 1'b0;
        end else begin
            if (w_write) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // A dropped NaN still counts as seen.
            if (w_capture && (w_cap_class == CLS_NAN)) begin
                r_nan_seen <= 1'b1;
            end
        end
    end

    assign w_head   = r_mem[r_rptr];
    assign rd_valid = (r_count != '0);
    assign rd_data  = rd_valid ? w_head.data : '0;
    assign rd_class = rd_valid ? w_head.cls  : '0;
    assign rd_sign  = rd_data[DATA_W-1];
    assign count    = r_count;
    assign overflow = r_overflow;
    assign nan_seen = r_nan_seen;

endmodule

// File: tb/tb_fp16_mac_result_sink.sv
// Self-checking bench for fp16_mac_result_sink: directed tables and sequences
// plus randomized traffic against a queue-based reference model.
module tb_fp16_mac_result_sink;

    localparam int L = 2;
    localparam int D = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        issue_valid;
    logic [15:0] data_out;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [2:0]  rd_class;
    logic        rd_sign;
    logic [3:0]  count;
    logic        overflow;
    logic        nan_seen;

    always #5 CLK = ~CLK;

    fp16_mac_result_sink #(.MAC_LATENCY(L), .FIFO_DEPTH(D)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .issue_valid (issue_valid),
        .data_out    (data_out),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_class    (rd_class),
        .rd_sign     (rd_sign),
        .count       (count),
        .overflow    (overflow),
        .nan_seen    (nan_seen)
    );

    typedef struct {
        logic [2:0]  cls;
        logic [15:0] data;
    } ent_t;

    typedef struct {
        logic [15:0] din;
        logic [2:0]  cls;
        logic        sgn;
    } vec_t;

    // Reference model: stored results, issue history (front = last cycle), flags.
    ent_t        mq[$];
    logic        mh[$];
    logic        m_ovf;
    logic        m_nan;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] bv [16];
    vec_t        tbl [8];

    function automatic logic [2:0] ref_class(input logic [15:0] d);
        int e;
        int m;
        e = int'(d[14:10]);
        m = int'(d[9:0]);
        if (e == 0)  return (m == 0) ? 3'd0 : 3'd1;
        if (e == 31) return (m == 0) ? 3'd3 : 3'd4;
        return 3'd2;
    endfunction

    function automatic logic [15:0] rand_data();
        logic       s;
        logic [9:0] m;
        s = 1'($urandom_range(0, 1));
        m = 10'($urandom_range(1, 1023));
        case ($urandom_range(0, 4))
            0:       return {s, 15'h0000};
            1:       return {s, 5'h00, m};
            2:       return {s, 5'h1f, 10'h000};
            3:       return {s, 5'h1f, m};
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic iv, input logic [15:0] dout, input logic rdy, input logic rst);
        logic cap;
        logic pop;
        logic full;
        logic [2:0] cls;
        if (rst) begin
            mq.delete();
            mh.delete();
            m_ovf = 1'b0;
            m_nan = 1'b0;
            return;
        end
        cap  = (mh.size() >= L) && mh[L-1];
        full = (mq.size() == D);
        pop  = (mq.size() != 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (cap) begin
            cls = ref_class(dout);
            if (cls == 3'd4) m_nan = 1'b1;
            if (!full || pop) mq.push_back('{cls: cls, data: dout});
            else m_ovf = 1'b1;
        end
        mh.push_front(iv);
        if (mh.size() > L) void'(mh.pop_back());
    endtask

    task automatic compare_model();
        logic        ev;
        logic [15:0] ed;
        logic [2:0]  ec;
        ev = (mq.size() != 0);
        ed = ev ? mq[0].data : 16'h0000;
        ec = ev ? mq[0].cls  : 3'd0;
        check("m_rd_valid", 32'(rd_valid), 32'(ev));
        check("m_rd_data",  32'(rd_data),  32'(ed));
        check("m_rd_class", 32'(rd_class), 32'(ec));
        check("m_rd_sign",  32'(rd_sign),  32'(ed[15]));
        check("m_count",    32'(count),    32'(mq.size()));
        check("m_overflow", 32'(overflow), 32'(m_ovf));
        check("m_nan_seen", 32'(nan_seen), 32'(m_nan));
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge.
    task automatic cycle(input logic iv, input logic [15:0] dout, input logic rdy, input logic rst);
        issue_valid = iv;
        data_out    = dout;
        rd_ready    = rdy;
        RESET       = rst;
        model_edge(iv, dout, rdy, rst);
        @(posedge CLK);
        #1;
        compare_model();
    endtask

    // Back-to-back issues of bv[0..n-1], each result presented L cycles later.
    task automatic burst(input int n, input logic rdy);
        for (int c = 0; c < n + L; c++) begin
            cycle(c < n, (c >= L) ? bv[c-L] : rand_data(), rdy, 1'b0);
        end
    endtask

    initial begin
        tbl[0] = '{din: 16'h7C00, cls: 3'd3, sgn: 1'b0};
        tbl[1] = '{din: 16'hFE00, cls: 3'd4, sgn: 1'b1};
        tbl[2] = '{din: 16'h0001, cls: 3'd1, sgn: 1'b0};
        tbl[3] = '{din: 16'h8000, cls: 3'd0, sgn: 1'b1};
        tbl[4] = '{din: 16'h3C00, cls: 3'd2, sgn: 1'b0};
        tbl[5] = '{din: 16'h7BFF, cls: 3'd2, sgn: 1'b0};
        tbl[6] = '{din: 16'h83FF, cls: 3'd1, sgn: 1'b1};
        tbl[7] = '{din: 16'hFC00, cls: 3'd3, sgn: 1'b1};

        RESET = 1'b1; issue_valid = 1'b0; data_out = 16'h0; rd_ready = 1'b0;
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);

        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data",  32'(rd_data),  32'h0);
        check("rst_rd_class", 32'(rd_class), 32'd0);
        check("rst_rd_sign",  32'(rd_sign),  32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_nan_seen", 32'(nan_seen), 32'd0);

        // Issue at cycle 0, result at cycle 2, visible at cycle 3 (no bypass).
        cycle(1'b1, rand_data(), 1'b0, 1'b0);
        cycle(1'b0, rand_data(), 1'b0, 1'b0);
        check("lat_no_bypass", 32'(rd_valid), 32'd0);
        cycle(1'b0, 16'h3C00, 1'b0, 1'b0);
        check("lat_rd_valid", 32'(rd_valid), 32'd1);
        check("lat_rd_data",  32'(rd_data),  32'h3C00);
        check("lat_rd_class", 32'(rd_class), 32'd2);
        check("lat_rd_sign",  32'(rd_sign),  32'd0);
        check("lat_count",    32'(count),    32'd1);
        cycle(1'b0, rand_data(), 1'b1, 1'b0);
        check("lat_drained", 32'(count), 32'd0);

        // Classification table read back in order.
        for (int i = 0; i < 8; i++) bv[i] = tbl[i].din;
        burst(8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("tbl_data",  32'(rd_data),  32'(tbl[i].din));
            check("tbl_class", 32'(rd_class), 32'(tbl[i].cls));
            check("tbl_sign",  32'(rd_sign),  32'(tbl[i].sgn));
            cycle(1'b0, rand_data(), 1'b1, 1'b0);
        end
        check("tbl_nan_seen", 32'(nan_seen), 32'd1);
        check("tbl_empty",    32'(rd_valid), 32'd0);

        // Nine captures with no reads: ninth dropped.
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) bv[i] = 16'h1000 + 16'(i * 16'h0111);
        burst(9, 1'b0);
        check("ovf_count", 32'(count),    32'd8);
        check("ovf_flag",  32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain", 32'(rd_data), 32'(bv[i]));
            cycle(1'b0, rand_data(), 1'b1, 1'b0);
        end
        check("ovf_ninth_absent", 32'(rd_valid), 32'd0);
        check("ovf_sticky",       32'(overflow), 32'd1);

        // Capture while full with a same-cycle pop.
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) bv[i] = 16'h2000 + 16'(i * 16'h0101);
        burst(8, 1'b0);
        cycle(1'b1, rand_data(), 1'b0, 1'b0);
        cycle(1'b0, rand_data(), 1'b0, 1'b0);
        cycle(1'b0, 16'h5A5A, 1'b1, 1'b0);
        check("fullpop_count",    32'(count),    32'd8);
        check("fullpop_overflow", 32'(overflow), 32'd0);
        for (int i = 1; i < 8; i++) begin
            check("fullpop_drain", 32'(rd_data), 32'(bv[i]));
            cycle(1'b0, rand_data(), 1'b1, 1'b0);
        end
        check("fullpop_tail", 32'(rd_data), 32'h5A5A);
        cycle(1'b0, rand_data(), 1'b1, 1'b0);

        // Reset with 4 stored and 2 in flight.
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) bv[i] = 16'h4400 + 16'(i);
        burst(4, 1'b0);
        check("midrst_pre_count", 32'(count), 32'd4);
        cycle(1'b1, rand_data(), 1'b0, 1'b0);
        cycle(1'b1, rand_data(), 1'b0, 1'b0);
        cycle(1'b0, 16'h3C00, 1'b0, 1'b1);
        check("midrst_count",    32'(count),    32'd0);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < L + 2; i++) begin
            cycle(1'b0, 16'h3C00, 1'b0, 1'b0);
            check("midrst_no_capture", 32'(count), 32'd0);
        end

        // rd_ready while empty must not move the read pointer.
        cycle(1'b0, rand_data(), 1'b1, 1'b0);
        cycle(1'b0, rand_data(), 1'b1, 1'b0);
        check("empty_rdy_count", 32'(count),    32'd0);
        check("empty_rdy_valid", 32'(rd_valid), 32'd0);
        cycle(1'b1, rand_data(), 1'b1, 1'b0);
        cycle(1'b0, rand_data(), 1'b1, 1'b0);
        cycle(1'b0, 16'h4242, 1'b1, 1'b0);
        check("empty_rdy_head",  32'(rd_data), 32'h4242);
        check("empty_rdy_count1", 32'(count),  32'd1);
        cycle(1'b0, rand_data(), 1'b1, 1'b0);

        // Randomized traffic: slow reader first to reach full/overflow, then mixed.
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            logic iv;
            logic rdy;
            logic rst;
            iv  = ($urandom_range(0, 3) != 0);
            rdy = (i < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 149) == 0);
            cycle(iv, rand_data(), rdy, rst);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp16_mac_result_sink.md
FP16_MAC_RESULT_SINK -- requirements
Module: fp16_mac_result_sink

Interface
REQ-001 The block SHALL have parameter MAC_LATENCY, default 2, which is the number of cycles from operand issue to a valid MAC data_out.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, which is the result buffer depth and SHALL be a power of two, at least 2.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port issue_valid, input, 1 bit: high in the cycle a data_in_A/B/C triple is presented to the MAC.
REQ-006 The block SHALL have port data_out, input, 16 bits: MAC result in FP16 format (1 sign, 5 exponent, 10 mantissa).
REQ-007 The block SHALL have port rd_ready, input, 1 bit: the consumer accepts the head entry.
REQ-008 The block SHALL have port rd_valid, output, 1 bit: the FIFO is non-empty.
REQ-009 The block SHALL have port rd_data, output, 16 bits: the head result.
REQ-010 The block SHALL have port rd_class, output, 3 bits: the head classification (0 ZERO, 1 SUB, 2 NORM, 3 INF, 4 NAN).
REQ-011 The block SHALL have port rd_sign, output, 1 bit: the head sign bit.
REQ-012 The block SHALL have port count, output, clog2(FIFO_DEPTH)+1 bits: the stored-entry count.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a result is dropped.
REQ-014 The block SHALL have port nan_seen, output, 1 bit: sticky flag, set when a NAN-class result is captured.

Function
REQ-015 issue_valid SHALL pass through a MAC_LATENCY-stage shift register; the last stage is capture, which samples data_out in that same cycle.
REQ-016 Classification SHALL be: exp=0 and mant=0 gives ZERO; exp=0 and mant≠0 gives SUB; exp=31 and mant=0 gives INF; exp=31 and mant≠0 gives NAN; all other values give NORM.
REQ-017 Each FIFO entry SHALL store {class, data_out}; rd_sign SHALL equal rd_data[15].
REQ-018 A pop SHALL occur exactly when rd_valid && rd_ready.
REQ-019 The FIFO SHALL be first-word fall-through: the head appears on rd_data/rd_class with no extra cycle.
REQ-020 A write SHALL occur when capture && (count<FIFO_DEPTH || pop).
REQ-021 When the FIFO is full, a same-cycle capture and pop SHALL both occur; count stays FIFO_DEPTH and overflow is not set.
REQ-022 When capture occurs, the FIFO is full and no pop occurs, the result SHALL be discarded and overflow SHALL be set and held until RESET.
REQ-023 A capture into an empty FIFO SHALL NOT bypass: rd_valid rises the cycle after the capture.
REQ-024 count SHALL be incremented by a write without a pop, decremented by a pop without a write, and unchanged when both or neither occur.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 rd_valid SHALL be (count≠0).
REQ-027 When rd_valid is 0, rd_data, rd_class and rd_sign SHALL be forced to 0.
REQ-028 nan_seen SHALL set on any captured NAN-class result, including a dropped one, and hold until RESET.
REQ-029 rd_ready while empty SHALL have no effect.

Reset
REQ-030 While RESET=1 at a rising CLK edge, the block SHALL clear the delay line, pointers, count, overflow and nan_seen.
REQ-031 After reset, the outputs SHALL be: rd_valid 0, rd_data 16'h0000, rd_class 0, rd_sign 0, count 0, overflow 0, nan_seen 0.
REQ-032 A reset asserted mid-operation SHALL discard all stored and in-flight results; issues made before reset SHALL never produce a capture.
REQ-033 Storage array contents SHALL NOT require reset, because outputs are masked per REQ-027.

Structure
REQ-034 The shared package fp16_pkg SHALL hold EXP_W=5, MAN_W=10, the EXP_MAX constant and the 3-bit class encoding constants.
REQ-035 Classification SHALL be a combinational sub-module, fp16_classify (16-bit in, class and sign out), reused by later FP16 blocks.
REQ-036 The delay line, FIFO and flags SHALL reside in fp16_mac_result_sink.

Verification (MAC_LATENCY=2, FIFO_DEPTH=8)
REQ-037 The bench SHALL drive issue_valid high at cycle 0 with data_out=16'h3C00 at cycle 2, and SHALL check that at cycle 3 rd_valid=1, rd_data=3C00, class NORM, sign 0 and count=1.
REQ-038 The bench SHALL capture 16'h7C00, 16'hFE00, 16'h0001 and 16'h8000, and SHALL check that they read back in order as INF/0, NAN/1, SUB/0 and ZERO/1, with nan_seen=1.
REQ-039 The bench SHALL make 9 consecutive captures with rd_ready=0, and SHALL check count=8 and overflow=1, and that draining returns the first 8 values in order with the 9th absent.
REQ-040 The bench SHALL make a capture while the FIFO is full with rd_ready=1, and SHALL check that count stays 8, overflow=0, and the new value lands at the tail.
REQ-041 The bench SHALL assert RESET for one cycle with 4 entries stored and 2 issues in flight, and SHALL check that next cycle count=0 and rd_valid=0, with no later capture.
REQ-042 The bench SHALL pulse rd_ready while the FIFO is empty, and SHALL check that count stays 0 and the pointers are unchanged.
